// File: rtl/lattice_block_drain_pkg.sv
// -----------------------------------------------------------------------------
// lattice_block_drain_pkg
// Shared constants and types for the lattice block drain path.
//   DATA_WIDTH / ADDRESS_WIDTH / NUM_DIRS : BRAM and stream geometry
//   BLOCK_CELLS                           : default cells per block
//   DIR_C0 .. DIR_CNW                     : D2Q9 lane indices in packed read data
//   state_e                               : drain FSM states
// Optional feature macro: LATTICE_DRAIN_CHECKSUM_EN (adds the StTrailer state).
// -----------------------------------------------------------------------------
package lattice_block_drain_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 10;
    localparam int unsigned BLOCK_CELLS   = 1024;
    localparam int unsigned NUM_DIRS      = 9;

    localparam int unsigned DIR_C0  = 0;
    localparam int unsigned DIR_CN  = 1;
    localparam int unsigned DIR_CNE = 2;
    localparam int unsigned DIR_CE  = 3;
    localparam int unsigned DIR_CSE = 4;
    localparam int unsigned DIR_CS  = 5;
    localparam int unsigned DIR_CSW = 6;
    localparam int unsigned DIR_CW  = 7;
    localparam int unsigned DIR_CNW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFetch,
        StLatch,
        StEmit,
`ifdef LATTICE_DRAIN_CHECKSUM_EN
        StTrailer,
`endif
        StDone
    } state_e;

endpackage

// File: rtl/lattice_block_drain_if.sv
// -----------------------------------------------------------------------------
// lattice_block_drain_if
// Valid/ready word stream carrying a drained lattice block off-chip.
//   m_data  : stream word
//   m_valid : word present (never depends on m_ready)
//   m_ready : sink accepts the word
//   m_last  : final word of the block
// Modports: master (drain side), slave (DMA/stream side).
// -----------------------------------------------------------------------------
interface lattice_block_drain_if;

    logic [lattice_block_drain_pkg::DATA_WIDTH-1:0] m_data;
    logic                                           m_valid;
    logic                                           m_ready;
    logic                                           m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/lattice_lane_select.sv
// -----------------------------------------------------------------------------
// lattice_lane_select
// Holding register for one cell's nine direction words plus a 9:1 lane mux.
//   i_clk, i_rst : clock, synchronous active-low reset
//   i_capture    : load all lanes from i_rd_data this cycle
//   i_rd_data    : packed BRAM read data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_lane       : lane to present on o_data
//   o_data       : selected holding-register word
// -----------------------------------------------------------------------------
module lattice_lane_select
    import lattice_block_drain_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_capture,
    input  logic [NUM_DIRS*DATA_WIDTH-1:0] i_rd_data,
    input  logic [3:0]                   i_lane,
    output logic [DATA_WIDTH-1:0]        o_data
);

    logic [DATA_WIDTH-1:0] r_hold [NUM_DIRS];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < int'(NUM_DIRS); k++) begin
                r_hold[k] <= '0;
            end
        end else if (i_capture) begin
            for (int k = 0; k < int'(NUM_DIRS); k++) begin
                r_hold[k] <= i_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Out-of-range lanes read as zero rather than X.
    always_comb begin
        o_data = '0;
        if (i_lane <= 4'(DIR_CNW)) begin
            o_data = r_hold[i_lane];
        end
    end

endmodule

// File: rtl/lattice_block_drain.sv
// -----------------------------------------------------------------------------
// lattice_block_drain
// Reads one lattice block from the nine "next" distribution BRAMs and
// serialises it as: header (block index), then per cell 0..BLOCK_CELLS-1 the
// nine direction words c0..cnw, optionally followed by an XOR checksum word.
//   i_clk, i_rst    : clock, synchronous active-low reset
//   i_start         : begin draining (accepted in idle only)
//   i_block_index   : header word, latched on an accepted start
//   o_busy, o_done  : busy level / one-cycle completion pulse
//   o_bram_addr     : shared read address to the nine BRAMs
//   o_bram_rd_en    : read strobe, data returns one cycle later
//   i_bram_rd_data  : packed read data of all nine lanes
//   m_if            : output word stream (master modport)
// Optional feature macro: LATTICE_DRAIN_CHECKSUM_EN (trailer word with XOR of
// every cell word, m_last moves onto the trailer).
// -----------------------------------------------------------------------------
module lattice_block_drain
    import lattice_block_drain_pkg::*;
#(
    parameter int unsigned BLOCK_CELLS_P = BLOCK_CELLS
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [DATA_WIDTH-1:0]          i_block_index,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [ADDRESS_WIDTH-1:0]       o_bram_addr,
    output logic                           o_bram_rd_en,
    input  logic [NUM_DIRS*DATA_WIDTH-1:0] i_bram_rd_data,
    lattice_block_drain_if.master          m_if
);

    localparam logic [ADDRESS_WIDTH:0] LAST_CELL = (ADDRESS_WIDTH+1)'(BLOCK_CELLS_P - 1);
    localparam logic [3:0]             LAST_LANE = 4'(DIR_CNW);

    state_e                  r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_index;
    logic [ADDRESS_WIDTH:0]  r_cell, w_cell_next;
    logic [3:0]              r_lane, w_lane_next;
    logic [DATA_WIDTH-1:0]   w_lane_data;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_capture;
    logic                    w_accept;

    assign w_accept  = (r_state == StIdle) && i_start;
    assign w_capture = (r_state == StLatch);

    lattice_lane_select u_lane_select (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_capture (w_capture),
        .i_rd_data (i_bram_rd_data),
        .i_lane    (r_lane),
        .o_data    (w_lane_data)
    );

`ifdef LATTICE_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (r_state == StEmit && m_if.m_ready) begin
            r_csum <= r_csum ^ w_lane_data;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
            r_index <= '0;
            r_cell  <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cell  <= w_cell_next;
            r_lane  <= w_lane_next;
            if (w_accept) begin
                r_index <= i_block_index;
            end
        end
    end

    // Outputs are decoded from registered state only, so m_valid never
    // sees m_ready combinationally and holds until the handshake.
    always_comb begin
        w_state_next = r_state;
        w_cell_next  = r_cell;
        w_lane_next  = r_lane;
        w_data       = '0;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        o_bram_rd_en = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_cell_next  = '0;
                    w_lane_next  = '0;
                    w_state_next = StHeader;
                end
            end
            StHeader: begin
                w_valid = 1'b1;
                w_data  = r_index;
                if (m_if.m_ready) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                o_bram_rd_en = 1'b1;
                w_state_next = StLatch;
            end
            StLatch: begin
                w_lane_next  = '0;
                w_state_next = StEmit;
            end
            StEmit: begin
                w_valid = 1'b1;
                w_data  = w_lane_data;
`ifndef LATTICE_DRAIN_CHECKSUM_EN
                w_last  = (r_lane == LAST_LANE) && (r_cell == LAST_CELL);
`endif
                if (m_if.m_ready) begin
                    if (r_lane != LAST_LANE) begin
                        w_lane_next = r_lane + 4'd1;
                    end else if (r_cell != LAST_CELL) begin
                        w_cell_next  = r_cell + 1'b1;
                        w_state_next = StFetch;
                    end else begin
`ifdef LATTICE_DRAIN_CHECKSUM_EN
                        w_state_next = StTrailer;
`else
                        w_state_next = StDone;
`endif
                    end
                end
            end
`ifdef LATTICE_DRAIN_CHECKSUM_EN
            StTrailer: begin
                w_valid = 1'b1;
                w_data  = r_csum;
                w_last  = 1'b1;
                if (m_if.m_ready) begin
                    w_state_next = StDone;
                end
            end
`endif
            StDone: begin
                o_busy       = 1'b0;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                o_busy       = 1'b0;
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_bram_addr  = r_cell[ADDRESS_WIDTH-1:0];
    assign m_if.m_data  = w_data;
    assign m_if.m_valid = w_valid;
    assign m_if.m_last  = w_last;

endmodule

// File: tb/tb_lattice_block_drain.sv
// -----------------------------------------------------------------------------
// tb_lattice_block_drain
// Self-checking bench for lattice_block_drain with a 4-cell block. A BRAM model
// returns 16*addr+lane; expected stream words are queued when a drain starts
// and compared as the DUT hands them over.
// Honours LATTICE_DRAIN_CHECKSUM_EN to expect the trailer word.
// -----------------------------------------------------------------------------
module tb_lattice_block_drain;
    import lattice_block_drain_pkg::*;

    localparam int BC = 4;
`ifdef LATTICE_DRAIN_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic                           start = 1'b0;
    logic [31:0]                    block_index = '0;
    logic                           busy;
    logic                           done;
    logic [ADDRESS_WIDTH-1:0]       bram_addr;
    logic                           bram_rd_en;
    logic [NUM_DIRS*DATA_WIDTH-1:0] bram_rd_data = '0;
    int                             rd_count = 0;
    logic [15:0]                    lfsr = 16'hACE1;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    lattice_block_drain_if u_if ();

    lattice_block_drain #(
        .BLOCK_CELLS_P (BC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_block_index  (block_index),
        .o_busy         (busy),
        .o_done         (done),
        .o_bram_addr    (bram_addr),
        .o_bram_rd_en   (bram_rd_en),
        .i_bram_rd_data (bram_rd_data),
        .m_if           (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_rd_en) begin
            rd_count <= rd_count + 1;
            for (int k = 0; k < 9; k++) begin
                bram_rd_data[k*32 +: 32] <= 32'(16 * int'(bram_addr) + k);
            end
        end
    end

    task automatic push_block(input logic [31:0] idx);
        logic [31:0] csum;
        exp_t        e;
        csum = '0;
        e.data = idx;
        e.last = 1'b0;
        q.push_back(e);
        for (int c = 0; c < BC; c++) begin
            for (int k = 0; k < 9; k++) begin
                e.data = 32'(16 * c + k);
                e.last = (c == BC - 1) && (k == 8) && !CHK;
                csum   = csum ^ e.data;
                q.push_back(e);
            end
        end
        if (CHK) begin
            e.data = csum;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    // One drain: start with idx, consume the stream, compare words against the
    // queue. abort_after >= 0 resets after that many transfers; restart_at >= 0
    // pulses a second start (index 0x9) once that many words have transferred.
    task automatic run_drain(input logic [31:0] idx, input bit lfsr_mode,
                             input int abort_after, input int restart_at,
                             input bit check_timing);
        int          cyc = 0;
        int          xfers = 0;
        int          last_cyc = -1;
        int          done_cyc = -1;
        int          n_exp;
        int          rd_base;
        bit          fin = 1'b0;
        bit          aborted = 1'b0;
        bit          restarted = 1'b0;
        bit          stall = 1'b0;
        logic [31:0] pdata = '0;
        logic        plast = 1'b0;
        exp_t        e;

        q.delete();
        push_block(idx);
        n_exp   = q.size();
        rd_base = rd_count;
        @(negedge clk);
        start       = 1'b1;
        block_index = idx;
        while (!fin && cyc < 600) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (abort_after >= 0 && xfers == abort_after) begin
                rst = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (u_if.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_state: valid=%b busy=%b done=%b, required 0/0/0",
                             u_if.m_valid, busy, done);
                end
                rst = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || u_if.m_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_quiet: done=%b valid=%b, required 0/0",
                                 done, u_if.m_valid);
                    end
                end
                q.delete();
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
                if (restart_at >= 0 && xfers == restart_at && !restarted) begin
                    start       = 1'b1;
                    block_index = 32'h9;
                    restarted   = 1'b1;
                end
                u_if.m_ready = lfsr_mode ? lfsr[0] : 1'b1;
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                #1;
                if (stall) begin
                    n_cmp++;
                    if (u_if.m_valid !== 1'b1 || u_if.m_data !== pdata
                        || u_if.m_last !== plast) begin
                        n_err++;
                        $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                                 u_if.m_valid, u_if.m_data, u_if.m_last, pdata, plast);
                    end
                end
                if (done === 1'b1) begin
                    done_cyc = cyc;
                    fin      = 1'b1;
                end
                if (u_if.m_valid === 1'b1 && u_if.m_ready === 1'b1) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_word: got %h, required no word", u_if.m_data);
                    end else begin
                        e = q.pop_front();
                        if (u_if.m_data !== e.data || u_if.m_last !== e.last) begin
                            n_err++;
                            $display("FAIL word%0d: data=%h last=%b, required %h %b",
                                     xfers, u_if.m_data, u_if.m_last, e.data, e.last);
                        end
                    end
                    xfers++;
                    last_cyc = cyc;
                end
                stall = (u_if.m_valid === 1'b1) && (u_if.m_ready !== 1'b1);
                pdata = u_if.m_data;
                plast = u_if.m_last;
            end
        end
        if (!aborted) begin
            n_cmp++;
            if (!fin) begin
                n_err++;
                $display("FAIL timeout: no done after %0d cycles, required done", cyc);
            end
            n_cmp++;
            if (xfers != n_exp) begin
                n_err++;
                $display("FAIL word_count: %0d words, required %0d", xfers, n_exp);
            end
            n_cmp++;
            if (done_cyc != last_cyc + 1) begin
                n_err++;
                $display("FAIL done_timing: done at %0d, required %0d", done_cyc, last_cyc + 1);
            end
            n_cmp++;
            if (rd_count - rd_base != BC) begin
                n_err++;
                $display("FAIL rd_pulses: %0d, required %0d", rd_count - rd_base, BC);
            end
            if (check_timing) begin
                n_cmp++;
                if (last_cyc != 11 * BC + 1 + int'(CHK)) begin
                    n_err++;
                    $display("FAIL latency: last transfer %0d cycles after start, required %0d",
                             last_cyc, 11 * BC + 1 + int'(CHK));
                end
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_done: done=%b busy=%b, required 0/0", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst          = 1'b0;
        start        = 1'b0;
        u_if.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (u_if.m_valid !== 1'b0 || u_if.m_last !== 1'b0 || u_if.m_data !== '0) begin
            n_err++;
            $display("FAIL reset_stream: valid=%b last=%b data=%h, required 0 0 0",
                     u_if.m_valid, u_if.m_last, u_if.m_data);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bram_rd_en !== 1'b0 || bram_addr !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b done=%b rd_en=%b addr=%h, required 0 0 0 0",
                     busy, done, bram_rd_en, bram_addr);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.m_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_basic_drain();
        run_drain(32'h5, 1'b0, -1, -1, 1'b1);
    endtask

    task automatic test_backpressure();
        run_drain(32'h5, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_drain(32'h5, 1'b0, 12, -1, 1'b0);
        run_drain(32'h7, 1'b0, -1, -1, 1'b1);
    endtask

    task automatic test_start_while_busy();
        run_drain(32'h5, 1'b0, -1, 5, 1'b1);
        // A fresh drain shows whether the ignored start disturbed the latched index.
        run_drain(32'hA, 1'b1, -1, -1, 1'b0);
    endtask

`ifdef LATTICE_DRAIN_CHECKSUM_EN
    task automatic test_checksum();
        run_drain(32'h5, 1'b1, -1, -1, 1'b0);
    endtask
`endif

    initial begin
        u_if.m_ready = 1'b0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_reset_mid();
        test_start_while_busy();
`ifdef LATTICE_DRAIN_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
